cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
- Shares one W-bit equality/inequality comparator datapath between two requesters.
- Per request: round-robin arbitration, operand and mode latching, one registered compare, one-cycle done pulse back to the winner.
- Sits between client logic and the xnor/xor comparator datapath with its bitwise and logical outputs.
- Also keeps a wrap-around count of completed operations.

Parameters:
- W, 4, operand and bitwise-result width.
- CW, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  2  request per requester; req[i] held high until done[i].
- a0  input  W  operand A, requester 0.
- b0  input  W  operand B, requester 0.
- a1  input  W  operand A, requester 1.
- b1  input  W  operand B, requester 1.
- mode  input  2  mode[i] for requester i: 0 = equals, 1 = not-equals.
- gnt  output  2  one-hot grant, held from acceptance through DONE.
- busy  output  1  high while state is not IDLE.
- done  output  2  one-cycle pulse on done[gnt index] when the result is valid.
- bitwise  output  W  registered bitwise result of the last completed op.
- logical  output  1  registered logical result of the last completed op.
- op_count  output  CW  completed operations, modulo 2^CW.

Behaviour:
- Reset, asynchronous, highest priority:
  - state = IDLE; priority pointer p = 0.
  - gnt, done, busy, bitwise, logical, op_count = 0; latched operands and mode = 0.
- FSM states: IDLE, EVAL, DONE.
- IDLE, cycle T:
  - If req == 0: stay in IDLE.
  - Else select the winner w:
    - only one req bit set: w is that requester;
    - both set: w = p.
  - On the edge ending T:
    - latch a_w, b_w, mode[w]; gnt = onehot(w); busy = 1;
    - go to EVAL.
- EVAL, cycle T+1: the comparator operates on the latched operands only.
  - mode 0: bitwise = bitwise XNOR of the latched A and B; logical = AND-reduce of that result (1 iff A == B).
  - mode 1: bitwise = bitwise XOR of the latched A and B; logical = OR-reduce of that result (1 iff A != B).
  - The mode-selected result is loaded into the bitwise/logical registers on the edge ending T+1; go to DONE.
- DONE, cycle T+2:
  - done[w] = 1; all other done bits 0; bitwise and logical valid.
  - On the edge ending T+2:
    - op_count += 1 (wraps 2^CW-1 -> 0);
    - p = 1 - w; gnt = 0; busy = 0;
    - go to IDLE.
- Latency: acceptance to done = 2 cycles. Minimum issue interval = 3 cycles; the next grant is possible in cycle T+3.
- Requester handshake:
  - The requester samples done[i] at the edge ending DONE and deasserts req[i] on that same edge if it has no further work.
  - If req[i] stays high, the request is a new one, arbitrated normally at T+3.
- bitwise and logical hold their value between operations. They change only on the edge leaving EVAL.
- Operand or mode changes after acceptance are ignored; the latched copies are used.
- req[w] dropping during EVAL or DONE: the operation still completes and done[w] still pulses.
- A req rising during a busy cycle is not seen until IDLE. Requests are never queued beyond the level of req.
- Fairness: with both requesters held high continuously, grants alternate 0,1,0,1... starting from the current p. Each requester is served at least once every 6 cycles.
- Reset mid-operation: immediate abort to the reset values above; no done pulse; op_count is not incremented.
- gnt is always one-hot or zero; done is never asserted for a non-granted requester.

Test Plan:
- Reset then idle: assert reset for 2 cycles with req = 2'b00 -> all outputs 0, busy stays 0, op_count stays 0 for 10 cycles.
- Single equals op: req = 2'b01, a0 = 4'b1010, b0 = 4'b1010, mode[0] = 0 -> gnt = 01 at T+1/T+2, done = 01 at T+2, bitwise = 1111, logical = 1, op_count = 1.
- Single not-equals op: req = 2'b10, a1 = 4'b1100, b1 = 4'b1010, mode[1] = 1 -> done = 10 at T+2, bitwise = 0110, logical = 1. Repeat with a1 = b1 = 4'b0011 -> bitwise = 0000, logical = 0.
- Contention: both req held high for 12 cycles from reset (p = 0) -> done sequence 01, 10, 01, 10, each 3 cycles apart, op_count = 4.
- Operand hold: accept a0 = 4'b0001, b0 = 4'b0001 with mode 0, change b0 to 4'b1111 in EVAL -> result still bitwise = 1111, logical = 1.
- Reset mid-op: assert reset during EVAL -> no done pulse, state IDLE, op_count unchanged at 0.
- Counter wrap: force 256 completed ops -> op_count returns to 0.

Source files
------------

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of a shared W-bit
// equality/inequality comparator, with a wrap-around completion counter.
module cmp_arbiter #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  b0,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  b1,
    input  logic [1:0]    mode,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [1:0]    done,
    output logic [W-1:0]  bitwise,
    output logic          logical,
    output logic [CW-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic          p_q;
    logic [1:0]    gnt_q;
    logic          busy_q;
    logic [1:0]    done_q;
    logic [W-1:0]  bitwise_q;
    logic          logical_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          mode_q;

    logic          win;
    logic [W-1:0]  xor_v;
    logic [W-1:0]  xnor_v;
    logic [W-1:0]  bitwise_d;
    logic          logical_d;

    // Pointer only breaks ties; a lone request always wins.
    always_comb begin
        win = (req == 2'b11) ? p_q : req[1];
    end

    always_comb begin
        xor_v     = a_q ^ b_q;
        xnor_v    = ~xor_v;
        bitwise_d = mode_q ? xor_v : xnor_v;
        logical_d = mode_q ? (|xor_v) : (&xnor_v);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            p_q       <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 2'b00;
            bitwise_q <= '0;
            logical_q <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        a_q     <= win ? a1 : a0;
                        b_q     <= win ? b1 : b0;
                        mode_q  <= mode[win];
                        gnt_q   <= win ? 2'b10 : 2'b01;
                        busy_q  <= 1'b1;
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    bitwise_q <= bitwise_d;
                    logical_q <= logical_d;
                    done_q    <= gnt_q;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 2'b00;
                    cnt_q   <= cnt_q + CW'(1);
                    p_q     <= ~gnt_q[1];
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bitwise  = bitwise_q;
    assign logical  = logical_q;
    assign op_count = cnt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: directed cases plus two random
// requester agents checked against a bit-level reference model.
module tb_cmp_arbiter;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]    mode = 2'b00;
    logic [1:0]    gnt;
    logic          busy;
    logic [1:0]    done;
    logic [W-1:0]  bitwise;
    logic          logical;
    logic [CW-1:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W:0]    q0[$];
    logic [W:0]    q1[$];
    int            done_log[$];
    logic [CW-1:0] exp_cnt = '0;
    logic [W:0]    last_res = '0;
    int            gnt_age = 0;

    cmp_arbiter #(.W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .mode(mode),
        .gnt(gnt), .busy(busy), .done(done),
        .bitwise(bitwise), .logical(logical), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit i of the result is 1 when the bits agree (equals) or differ (not-equals).
    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic m);
        logic [W-1:0] bw;
        logic lg;
        for (int k = 0; k < W; k++) bw[k] = (a[k] == b[k]) ? ~m : m;
        lg = m ? (a != b) : (a == b);
        return {bw, lg};
    endfunction

    task automatic set_ops(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic m);
        if (i == 0) begin
            a0 = a; b0 = b; mode[0] = m;
        end else begin
            a1 = a; b1 = b; mode[1] = m;
        end
    endtask

    task automatic push_exp(input int i, input logic [W:0] e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < 6);
        chk($sformatf("done%0d_within_bound", i), 32'(done[i]), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_op(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic m);
        set_ops(i, a, b, m);
        push_exp(i, model(a, b, m));
        req[i] = 1'b1;
        wait_done(i);
        @(posedge clk);
        #1 req[i] = 1'b0;
    endtask

    task automatic agent(input int i, input int nops);
        logic [W-1:0] a, b;
        logic m;
        bit keep = 0;
        bit seen;
        int n;
        for (int k = 0; k < nops; k++) begin
            if (!keep) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            a = W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? a : W'($urandom);
            m = 1'($urandom_range(0, 1));
            set_ops(i, a, b, m);
            push_exp(i, model(a, b, m));
            req[i] = 1'b1;
            n = 0;
            seen = 0;
            do begin
                @(negedge clk);
                n++;
                // Once accepted, the inputs are garbage to the DUT.
                if (gnt[i] && !seen) begin
                    seen = 1;
                    set_ops(i, W'($urandom), W'($urandom),
                            1'($urandom_range(0, 1)));
                end
            end while (!done[i] && n < 6);
            chk($sformatf("agent%0d_service_wait", i), 32'(done[i]), 32'd1);
            @(posedge clk);
            #1;
            keep = (k < nops - 1) && ($urandom_range(0, 1) == 1);
            if (!keep) req[i] = 1'b0;
        end
    endtask

    // Scoreboard monitor: invariants every cycle, results on each done.
    initial begin
        logic [W:0] e;
        int idx;
        forever begin
            @(negedge clk);
            if (reset) begin
                q0.delete();
                q1.delete();
                exp_cnt  = '0;
                last_res = '0;
                gnt_age  = 0;
            end else begin
                gnt_age = (gnt != 2'b00) ? gnt_age + 1 : 0;
                chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
                chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
                chk("op_count", 32'(op_count), 32'(exp_cnt));
                if (done != 2'b00) begin
                    idx = int'(done[1]);
                    chk("done_onehot", 32'($onehot(done)), 32'd1);
                    chk("done_matches_gnt", 32'(gnt), 32'(done));
                    chk("done_latency", gnt_age, 2);
                    if ((idx == 0 && q0.size() == 0) ||
                        (idx == 1 && q1.size() == 0)) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                        last_res = e;
                    end
                    exp_cnt = exp_cnt + 1'b1;
                    done_log.push_back(idx);
                end
                chk("result", 32'({bitwise, logical}), 32'(last_res));
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bitwise", 32'(bitwise), 32'd0);
        chk("rst_logical", 32'(logical), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_op_count", 32'(op_count), 32'd0);
        end
        @(posedge clk);
        #1;

        do_op(0, 4'b1010, 4'b1010, 1'b0);
        do_op(1, 4'b1100, 4'b1010, 1'b1);
        do_op(1, 4'b0011, 4'b0011, 1'b1);
        chk("ops_count_3", 32'(op_count), 32'd3);

        do_reset();
        set_ops(0, 4'd5, 4'd5, 1'b0);
        set_ops(1, 4'd3, 4'd9, 1'b1);
        for (int k = 0; k < 2; k++) begin
            push_exp(0, model(4'd5, 4'd5, 1'b0));
            push_exp(1, model(4'd3, 4'd9, 1'b1));
        end
        done_log.delete();
        req = 2'b11;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1 req = 2'b00;
        chk("contention_len", done_log.size(), 4);
        if (done_log.size() == 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("contention_order_%0d", k), done_log[k], k % 2);
        @(negedge clk);
        chk("contention_count", 32'(op_count), 32'd4);

        @(posedge clk);
        #1;
        set_ops(0, 4'b0001, 4'b0001, 1'b0);
        push_exp(0, model(4'b0001, 4'b0001, 1'b0));
        req[0] = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt[0] && n < 3);
            chk("hold_grant_seen", 32'(gnt[0]), 32'd1);
        end
        #1 b0 = 4'b1111;
        mode[0] = 1'b1;
        wait_done(0);
        chk("hold_bitwise", 32'(bitwise), 32'hF);
        chk("hold_logical", 32'(logical), 32'd1);
        @(posedge clk);
        #1 req[0] = 1'b0;

        do_reset();
        set_ops(0, 4'b0110, 4'b0110, 1'b0);
        push_exp(0, model(4'b0110, 4'b0110, 1'b0));
        req[0] = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt[0] && n < 3);
            chk("midop_grant_seen", 32'(gnt[0]), 32'd1);
        end
        #1 reset = 1'b1;
        req = 2'b00;
        #1;
        chk("midop_gnt", 32'(gnt), 32'd0);
        chk("midop_busy", 32'(busy), 32'd0);
        chk("midop_done", 32'(done), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midop_no_done", 32'(done), 32'd0);
            chk("midop_count", 32'(op_count), 32'd0);
        end

        do_reset();
        fork
            agent(0, 140);
            agent(1, 140);
        join
        repeat (3) @(negedge clk);
        chk("rand_q0_empty", q0.size(), 0);
        chk("rand_q1_empty", q1.size(), 0);
        chk("wrap_count", 32'(op_count), 32'(280 % 256));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
